// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: default sizes and
// the next-PC source encoding chosen by the priority decode.
package pc_pkg;

    localparam int DEFAULT_ADDR_W      = 6;
    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_src_e;

endpackage

// File: rtl/ra_stack.sv
// Return-address LIFO. Only the count is reset; storage beyond the count
// is don't-care and is never presented as a valid top entry by the caller.
module ra_stack
    import pc_pkg::*;
#(
    parameter  int ADDR_W = DEFAULT_ADDR_W,
    parameter  int DEPTH  = DEFAULT_STACK_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx   = IDX_W'(count_q);
    assign rd_idx   = IDX_W'(count_q - CNT_W'(1));
    assign data_out = mem_q[rd_idx];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

    // Push writes the slot just above the top; pop only moves the count down.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = data_in;
            count_d       = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register; reset empties the stack without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage, never cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch, call and return. One action per enabled
// cycle, priority ret > call > branch > increment; stack faults hold the PC
// and set a sticky error flag.
module pc_unit
    import pc_pkg::*;
#(
    parameter  int                ADDR_W      = DEFAULT_ADDR_W,
    parameter  int                STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter  logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              branch_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] addr_out,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              err
);

    pc_src_e           pc_src;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] ret_addr;
    logic              err_q;
    logic              err_d;

    assign pc_plus1 = addr_q + ADDR_W'(1);
    assign addr_out = addr_q;
    assign err      = err_q;

    ra_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ra_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (pc_src == PC_CALL),
        .pop      (pc_src == PC_RET),
        .data_in  (pc_plus1),
        .data_out (ret_addr),
        .count    (stack_cnt),
        .full     (stack_full),
        .empty    (stack_empty)
    );

    // Priority decode of the commands; a faulting call/ret degrades to hold.
    always_comb begin
        pc_src = PC_HOLD;
        err_d  = err_q;
        if (pc_en) begin
            if (ret_en) begin
                if (stack_empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_src = PC_RET;
                end
            end else if (call_en) begin
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    pc_src = PC_CALL;
                end
            end else if (branch_en) begin
                pc_src = PC_BRANCH;
            end else begin
                pc_src = PC_INC;
            end
        end
    end

    // Next PC value for the selected source.
    always_comb begin
        addr_d = addr_q;
        case (pc_src)
            PC_INC:    addr_d = pc_plus1;
            PC_BRANCH: addr_d = branch_addr;
            PC_CALL:   addr_d = branch_addr;
            PC_RET:    addr_d = ret_addr;
            default:   addr_d = addr_q;
        endcase
    end

    // PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= RESET_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations plus
// random traffic, all compared every cycle against a queue-based model.
module tb_pc_unit;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int MODN   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              pc_en;
    logic              branch_en;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] addr_out;
    logic [CNT_W-1:0]  stack_cnt;
    logic              stack_full;
    logic              stack_empty;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    int m_pc;
    int m_stk[$];
    bit m_err;

    pc_unit #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .branch_en   (branch_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .branch_addr (branch_addr),
        .addr_out    (addr_out),
        .stack_cnt   (stack_cnt),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs at a falling edge, return at the next falling edge.
    task automatic apply_stimulus(input bit r, input bit en, input bit br, input bit ca,
                                  input bit re, input int addr);
        rst         = r;
        pc_en       = en;
        branch_en   = br;
        call_en     = ca;
        ret_en      = re;
        branch_addr = ADDR_W'(addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference behaviour: one action per enabled edge from the command rules.
    always @(posedge clk) begin
        if (rst) begin
            m_pc  = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (pc_en) begin
            if (ret_en) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (call_en) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else begin
                    m_stk.push_back((m_pc + 1) % MODN);
                    m_pc = int'(branch_addr);
                end
            end else if (branch_en) begin
                m_pc = int'(branch_addr);
            end else begin
                m_pc = (m_pc + 1) % MODN;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("addr_out", int'(addr_out), m_pc);
            check_output("stack_cnt", int'(stack_cnt), m_stk.size());
            check_output("stack_full", int'(stack_full), int'(m_stk.size() == DEPTH));
            check_output("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
            check_output("err", int'(err), int'(m_err));
        end
    end

    initial begin
        rst = 1'b1; pc_en = 1'b0; branch_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        branch_addr = '0;
        @(negedge clk);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        check_output("reset_addr", int'(addr_out), 0);
        check_output("reset_cnt", int'(stack_cnt), 0);
        check_output("reset_err", int'(err), 0);

        // Free-running increment with wrap.
        for (int i = 0; i < 65; i++) begin
            apply_stimulus(0, 1, 0, 0, 0, 0);
            check_output("inc_seq", int'(addr_out), (i + 1) % MODN);
        end
        check_output("inc_err", int'(err), 0);

        // Branch, then stalled branches are ignored.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 0, 0, 0);
        check_output("at_pc5", int'(addr_out), 5);
        apply_stimulus(0, 1, 1, 0, 0, 20);
        check_output("branch20", int'(addr_out), 20);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 1, 0, 0, 3 + i);
            check_output("stall_hold", int'(addr_out), 20);
        end

        // Call / increment / return.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0, 10);
        apply_stimulus(0, 1, 0, 1, 0, 40);
        check_output("call40", int'(addr_out), 40);
        check_output("call_cnt", int'(stack_cnt), 1);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        check_output("inc41", int'(addr_out), 41);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("ret11", int'(addr_out), 11);
        check_output("ret_cnt", int'(stack_cnt), 0);
        check_output("ret_err", int'(err), 0);

        // Overflow on the fifth call, then unwind in reverse order.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0, 10);
        apply_stimulus(0, 1, 0, 1, 0, 20);
        apply_stimulus(0, 1, 0, 1, 0, 30);
        apply_stimulus(0, 1, 0, 1, 0, 40);
        apply_stimulus(0, 1, 0, 1, 0, 50);
        check_output("full_cnt", int'(stack_cnt), 4);
        check_output("full_flag", int'(stack_full), 1);
        apply_stimulus(0, 1, 0, 1, 0, 60);
        check_output("ovf_hold", int'(addr_out), 50);
        check_output("ovf_err", int'(err), 1);
        check_output("ovf_cnt", int'(stack_cnt), 4);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("pop41", int'(addr_out), 41);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("pop31", int'(addr_out), 31);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("pop21", int'(addr_out), 21);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("pop11", int'(addr_out), 11);
        check_output("pop_empty", int'(stack_empty), 1);

        // Underflow is sticky until reset.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0, 7);
        apply_stimulus(0, 1, 0, 0, 1, 0);
        check_output("unf_hold", int'(addr_out), 7);
        check_output("unf_err", int'(err), 1);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0, 0);
        check_output("unf_pc", int'(addr_out), 10);
        check_output("unf_sticky", int'(err), 1);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("unf_clear", int'(err), 0);

        // All commands at once: return wins; reset mid-call wipes the stack.
        apply_stimulus(0, 1, 1, 0, 0, 32);
        apply_stimulus(0, 1, 0, 1, 0, 50);
        apply_stimulus(0, 1, 1, 1, 1, 12);
        check_output("prio_ret", int'(addr_out), 33);
        check_output("prio_cnt", int'(stack_cnt), 0);
        apply_stimulus(0, 1, 0, 1, 0, 1);
        apply_stimulus(0, 1, 0, 1, 0, 2);
        apply_stimulus(0, 1, 0, 1, 0, 3);
        check_output("pre_rst_cnt", int'(stack_cnt), 3);
        apply_stimulus(1, 1, 0, 1, 0, 44);
        check_output("rst_addr", int'(addr_out), 0);
        check_output("rst_cnt", int'(stack_cnt), 0);
        check_output("rst_err", int'(err), 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        check_output("post_rst_inc", int'(addr_out), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(63) == 0,
                           $urandom_range(3) != 0,
                           $urandom_range(2) == 0,
                           $urandom_range(2) == 0,
                           $urandom_range(3) == 0,
                           int'($urandom_range(MODN - 1)));
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, 6, program-counter width in bits (>=2).
REQ-002 Parameter STACK_DEPTH, 4, return-address stack entries (>=1).
REQ-003 Parameter RESET_ADDR, 0, value loaded into the PC by reset (ADDR_W bits).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_en  input  1  advance enable; 0 = stall, all other commands ignored.
REQ-007 branch_en  input  1  load branch_addr into the PC.
REQ-008 call_en  input  1  push return address, then load branch_addr.
REQ-009 ret_en  input  1  pop the return-address stack into the PC.
REQ-010 branch_addr  input  ADDR_W  target for branch/call.
REQ-011 addr_out  output  ADDR_W  current PC, registered.
REQ-012 stack_cnt  output  $clog2(STACK_DEPTH+1)  valid stack entries.
REQ-013 stack_full / stack_empty  output  1 each  stack_cnt==STACK_DEPTH / stack_cnt==0, combinational from the count.
REQ-014 err  output  1  sticky overflow/underflow flag.

Function
REQ-015 Per cycle with pc_en=1 the block SHALL select exactly one action, priority ret_en > call_en > branch_en > increment.
REQ-016 Increment: addr_out <= addr_out+1 mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
REQ-017 Branch: addr_out <= branch_addr; stack unchanged.
REQ-018 Call, stack not full: push (addr_out+1 mod 2^ADDR_W), stack_cnt+1, addr_out <= branch_addr, all in the same edge.
REQ-019 Call, stack full: no push, addr_out holds, err <= 1.
REQ-020 Ret, stack not empty: addr_out <= top entry, stack_cnt-1.
REQ-021 Ret, stack empty: addr_out holds, err <= 1.
REQ-022 pc_en=0: addr_out, stack contents, stack_cnt, err SHALL all hold, regardless of branch/call/ret inputs.
REQ-023 Latency: every action is visible on addr_out one clock after the sampling edge; no combinational input-to-addr_out path.
REQ-024 Stack is LIFO; entries beyond stack_cnt are don't-care and SHALL never appear on addr_out.
REQ-025 Once set, err SHALL remain 1 until rst; faulting cycles do not alter stack_cnt.

Reset
REQ-026 With rst=1 at an edge: addr_out <= RESET_ADDR, stack_cnt <= 0, err <= 0; rst overrides pc_en and all commands.
REQ-027 Reset mid-call/ret SHALL discard the pending action and all stacked addresses; stack storage needs no clearing.
REQ-028 First action after reset release SHALL operate on RESET_ADDR.

Structure
REQ-029 Shared package pc_pkg SHALL hold the next-PC source enum (PC_HOLD, PC_INC, PC_BRANCH, PC_CALL, PC_RET) and the default width/depth constants.
REQ-030 Return-address storage SHALL be sub-module ra_stack (push, pop, data in/out, count, full, empty), instantiated once; pc_unit contains the priority decode and the PC register.

Verification (ADDR_W=6, STACK_DEPTH=4, RESET_ADDR=0)
REQ-031 Reset then pc_en=1 for 65 cycles -> addr_out 0,1,...,63,0,1; err=0.
REQ-032 At PC=5 branch_en=1, branch_addr=20 -> next addr_out=20; then pc_en=0 with branch_en=1 for 3 cycles -> addr_out stays 20.
REQ-033 At PC=10 call to 40, increment to 41, ret -> addr_out 40, 41, 11; stack_cnt 1,1,0; err=0.
REQ-034 Five calls with stack empty -> fourth leaves stack_cnt=4, stack_full=1; fifth holds addr_out, sets err=1; four rets return pushed addresses in reverse order.
REQ-035 ret_en with stack empty at PC=7 -> addr_out stays 7, err=1, err held through later normal increments until rst.
REQ-036 call_en, branch_en, ret_en together with one entry (value 33) stacked -> addr_out=33, stack_cnt=0; rst asserted with stack_cnt=3 -> addr_out=0, stack_cnt=0, err=0 next cycle.
